// File: rtl/packetgen_pkg.sv
// Shared definitions for the packet generator egress stage.
//   ingress_state_e : ingress frame FSM states
//   clog2()         : ceiling log2 for parameter arithmetic
//   last_slice()    : index of the highest output slice with a nonzero keep
package packetgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // waiting for the first beat of a frame
    ST_ACCEPT = 2'd1,  // writing the current frame into the FIFO
    ST_DROP   = 2'd2   // discarding the rest of the current frame
  } ingress_state_e;

  // Widest input keep vector last_slice() can inspect (S_DATA_WIDTH up to 2048).
  localparam int unsigned MAX_KEEP_W = 256;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Highest slice k (k < ratio) whose m_keep_w keep bits are not all zero.
  // An all-zero keep returns 0, so at least one slice is always emitted.
  function automatic logic [5:0] last_slice(input logic [MAX_KEEP_W-1:0] keep,
                                            input int unsigned ratio,
                                            input int unsigned m_keep_w);
    logic [MAX_KEEP_W-1:0] mask;
    logic [5:0]            idx;
    mask = ~({MAX_KEEP_W{1'b1}} << m_keep_w);
    idx  = '0;
    for (int unsigned k = 0; k < 64; k++) begin
      if (k < ratio && |((keep >> (k * m_keep_w)) & mask)) idx = 6'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/packetgen_frame_fifo.sv
// Frame FIFO: RAM with a speculative write pointer and a commit pointer.
// The reader only sees words below wr_commit, so a frame becomes visible
// atomically once its last word is committed, and a partial frame can be
// discarded by rewinding the write pointer.
//   wr_en_i / wr_data_i : write one word at wr_ptr
//   commit_i            : publish everything up to and including this write
//   rewind_i            : move wr_ptr back to the start of the open frame
//   full_o              : wr_ptr - rd_ptr == DEPTH
//   rd_en_i / rd_data_o : pop the word at rd_ptr (combinational read)
//   empty_o             : no committed word available
module packetgen_frame_fifo
  import packetgen_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             commit_i,
  input  logic             rewind_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int unsigned AW = clog2(DEPTH);
  // One extra bit distinguishes full from empty; pointers wrap mod 2*DEPTH.
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    wr_commit_q, wr_commit_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

  // NOTE: the storage array has no reset; its contents are unreachable until
  // written, and leaving it out of reset lets it map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    rd_ptr_d    = rd_ptr_q;
    // Frames are committed in order, so the open frame always starts at
    // wr_commit; rewinding to it discards exactly the partial frame.
    if (rewind_i)     wr_ptr_d = wr_commit_q;
    else if (wr_en_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (commit_i)     wr_commit_d = wr_ptr_q + 1'b1;
    if (rd_en_i)      rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Space is judged against the registered rd_ptr: a word popped this cycle
  // becomes reusable only from the next cycle.
  assign full_o    = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign empty_o   = (rd_ptr_q == wr_commit_q);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/packetgen_egress.sv
// Egress stage: buffers whole frames from the unstallable wide packetgen
// stream and serialises them onto a narrower AXI-Stream with backpressure.
// Frames that do not fit are dropped whole and counted.
//   s_axis_*       : S_DATA_WIDTH input stream, no tready
//   m_axis_*       : M_DATA_WIDTH output stream honouring m_axis_tready
//   clear_counters : synchronous clear of both counters (wins over increments)
//   frame_count    : committed frames, saturating
//   drop_count     : dropped frames, saturating
module packetgen_egress
  import packetgen_pkg::*;
#(
  parameter int unsigned S_DATA_WIDTH = 512,
  parameter int unsigned M_DATA_WIDTH = 64,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [S_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic [M_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  input  logic                      clear_counters,
  output logic [COUNT_WIDTH-1:0]    frame_count,
  output logic [COUNT_WIDTH-1:0]    drop_count
);

  localparam int unsigned S_KEEP_W = S_DATA_WIDTH / 8;
  localparam int unsigned M_KEEP_W = M_DATA_WIDTH / 8;
  localparam int unsigned RATIO    = S_DATA_WIDTH / M_DATA_WIDTH;
  localparam int unsigned IDX_W    = (RATIO > 1) ? clog2(RATIO) : 1;
  localparam int unsigned ENTRY_W  = S_DATA_WIDTH + S_KEEP_W + 1;

  // ---------------- frame FIFO ----------------
  logic               fifo_wr_en, fifo_commit, fifo_rewind, fifo_full;
  logic               fifo_rd_en, fifo_empty;
  logic [ENTRY_W-1:0] fifo_rd_data;

  packetgen_frame_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (fifo_wr_en),
    .wr_data_i ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .commit_i  (fifo_commit),
    .rewind_i  (fifo_rewind),
    .full_o    (fifo_full),
    .rd_en_i   (fifo_rd_en),
    .rd_data_o (fifo_rd_data),
    .empty_o   (fifo_empty)
  );

  // ---------------- ingress FSM ----------------
  ingress_state_e state_q, state_d;
  logic           drop_evt;

  always_comb begin
    state_d     = state_q;
    fifo_wr_en  = 1'b0;
    fifo_commit = 1'b0;
    fifo_rewind = 1'b0;
    drop_evt    = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACCEPT: begin
        if (s_axis_tvalid) begin
          if (!fifo_full) begin
            fifo_wr_en  = 1'b1;
            fifo_commit = s_axis_tlast;
            state_d     = s_axis_tlast ? ST_IDLE : ST_ACCEPT;
          end else begin
            // Discard any words already written for this frame; a beat that
            // is itself the last one closes the drop immediately.
            fifo_rewind = (state_q == ST_ACCEPT);
            drop_evt    = s_axis_tlast;
            state_d     = s_axis_tlast ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          drop_evt = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- statistics ----------------
  logic [COUNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (clear_counters) begin
      frame_cnt_d = '0;
      drop_cnt_d  = '0;
    end else begin
      if (fifo_commit && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
      if (drop_evt    && drop_cnt_q  != '1) drop_cnt_d  = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;

  // ---------------- serialiser ----------------
  logic [S_DATA_WIDTH-1:0] word_data_q, word_data_d;
  logic [S_KEEP_W-1:0]     word_keep_q, word_keep_d;
  logic                    word_last_q, word_last_d;
  logic [IDX_W-1:0]        slice_q, slice_d, end_q, end_d;
  logic                    valid_q, valid_d;
  logic [IDX_W-1:0]        rd_end;
  logic                    word_done;

  logic                    rd_last;
  logic [S_KEEP_W-1:0]     rd_keep;
  assign rd_last = fifo_rd_data[ENTRY_W-1];
  assign rd_keep = fifo_rd_data[S_DATA_WIDTH +: S_KEEP_W];

  // Only the last word of a frame can end early.
  assign rd_end = rd_last ? IDX_W'(last_slice(MAX_KEEP_W'(rd_keep), RATIO, M_KEEP_W))
                          : IDX_W'(RATIO - 1);

  assign word_done = valid_q && m_axis_tready && (slice_q == end_q);
  // Refill in the same cycle the final slice leaves, so words stream back to back.
  assign fifo_rd_en = (!valid_q || word_done) && !fifo_empty;

  always_comb begin
    word_data_d = word_data_q;
    word_keep_d = word_keep_q;
    word_last_d = word_last_q;
    slice_d     = slice_q;
    end_d       = end_q;
    valid_d     = valid_q;
    if (fifo_rd_en) begin
      word_data_d = fifo_rd_data[S_DATA_WIDTH-1:0];
      word_keep_d = rd_keep;
      word_last_d = rd_last;
      slice_d     = '0;
      end_d       = rd_end;
      valid_d     = 1'b1;
    end else if (word_done) begin
      valid_d = 1'b0;
    end else if (valid_q && m_axis_tready) begin
      slice_d = slice_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_data_q <= '0;
      word_keep_q <= '0;
      word_last_q <= 1'b0;
      slice_q     <= '0;
      end_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      word_data_q <= word_data_d;
      word_keep_q <= word_keep_d;
      word_last_q <= word_last_d;
      slice_q     <= slice_d;
      end_q       <= end_d;
      valid_q     <= valid_d;
    end
  end

  logic [RATIO-1:0][M_DATA_WIDTH-1:0] data_slices;
  logic [RATIO-1:0][M_KEEP_W-1:0]     keep_slices;
  assign data_slices = word_data_q;
  assign keep_slices = word_keep_q;

  assign m_axis_tdata  = data_slices[slice_q];
  assign m_axis_tkeep  = keep_slices[slice_q];
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = valid_q && word_last_q && (slice_q == end_q);

endmodule

// File: tb/tb_packetgen_egress.sv
module tb_packetgen_egress;

  logic         clk;
  logic         rst_n;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         clear_counters;
  logic [3:0]   frame_count;
  logic [3:0]   drop_count;

  packetgen_egress #(
    .S_DATA_WIDTH (512),
    .M_DATA_WIDTH (64),
    .DEPTH        (4),
    .COUNT_WIDTH  (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .clear_counters (clear_counters),
    .frame_count    (frame_count),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    beats_seen = 0;
  int    ready_mode = 0;  // 0: always ready, 1: pattern 1,0,0,1, 2: never ready

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gen_byte(input int id, input int idx);
    return 8'((id * 37 + idx * 11 + 5) % 256);
  endfunction

  // Expected M-beats: 8 bytes per beat, low-order first, zero past the end.
  task automatic push_expected(input int id, input int nbytes);
    int nb;
    nb = (nbytes + 7) / 8;
    for (int m = 0; m < nb; m++) begin
      beat_t e;
      e.data = '0;
      e.keep = '0;
      for (int j = 0; j < 8; j++) begin
        if (m * 8 + j < nbytes) begin
          e.data[j*8 +: 8] = gen_byte(id, m * 8 + j);
          e.keep[j]        = 1'b1;
        end
      end
      e.last = (m == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input int id, input int nbytes, input bit push, input bit clr_last);
    int nw;
    nw = (nbytes + 63) / 64;
    if (push) push_expected(id, nbytes);
    for (int w = 0; w < nw; w++) begin
      @(posedge clk); #1;
      s_axis_tdata = '0;
      s_axis_tkeep = '0;
      for (int b = 0; b < 64; b++) begin
        if (w * 64 + b < nbytes) begin
          s_axis_tdata[b*8 +: 8] = gen_byte(id, w * 64 + b);
          s_axis_tkeep[b]        = 1'b1;
        end
      end
      s_axis_tvalid  = 1'b1;
      s_axis_tlast   = (w == nw - 1);
      clear_counters = clr_last && (w == nw - 1);
    end
    @(posedge clk); #1;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    clear_counters = 1'b0;
    s_axis_tdata   = '0;
    s_axis_tkeep   = '0;
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clear_counters = 1'b1;
    @(posedge clk); #1 clear_counters = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats_seen < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wait_beats_reached", 64'(beats_seen >= target), 64'd1);
  endtask

  // Downstream ready generator.
  initial begin
    int phase;
    phase = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       m_axis_tready = (phase == 0) || (phase == 3);
        2:       m_axis_tready = 1'b0;
        default: m_axis_tready = 1'b1;
      endcase
      phase = (phase + 1) % 4;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks that a
  // stalled beat holds steady until it is taken.
  bit          stall_hold = 0;
  logic [63:0] st_data;
  logic [9:0]  st_ctrl;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_hold = 0;
    end else begin
      if (stall_hold) begin
        check("stall_data", m_axis_tdata, st_data);
        check("stall_ctrl", {m_axis_tvalid, m_axis_tkeep, m_axis_tlast}, st_ctrl);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h keep %0h, want no beat", m_axis_tdata, m_axis_tkeep);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", m_axis_tdata, e.data);
          check("beat_keep", m_axis_tkeep, e.keep);
          check("beat_last", m_axis_tlast, e.last);
        end
      end
      stall_hold = m_axis_tvalid && !m_axis_tready;
      st_data    = m_axis_tdata;
      st_ctrl    = {m_axis_tvalid, m_axis_tkeep, m_axis_tlast};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n          = 1'b0;
    s_axis_tdata   = '0;
    s_axis_tkeep   = '0;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    clear_counters = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast",  m_axis_tlast, 0);
    check("rst_tdata",  m_axis_tdata, 0);
    check("rst_tkeep",  m_axis_tkeep, 0);
    check("rst_frames", frame_count, 0);
    check("rst_drops",  drop_count, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 192-byte frame: 24 full beats, tlast on the 24th.
    base = beats_seen;
    send_frame(1, 192, 1, 0);
    drain("t1");
    check("t1_beats",  64'(beats_seen - base), 64'd24);
    check("t1_frames", frame_count, 1);
    check("t1_drops",  drop_count, 0);

    // 60-byte single-word frame: 8 beats, last keep 0x0F; valid two cycles after tlast.
    base = beats_seen;
    send_frame(2, 60, 1, 0);
    @(negedge clk);
    check("t2_lat_n1", m_axis_tvalid, 0);
    @(negedge clk);
    check("t2_lat_n2", m_axis_tvalid, 1);
    drain("t2");
    check("t2_beats",  64'(beats_seen - base), 64'd8);
    check("t2_frames", frame_count, 2);

    // Two 192-byte frames with ready toggling 1,0,0,1.
    do_clear();
    ready_mode = 1;
    base = beats_seen;
    send_frame(3, 192, 1, 0);
    repeat (40) @(posedge clk);
    send_frame(4, 192, 1, 0);
    drain("t3");
    check("t3_beats",  64'(beats_seen - base), 64'd48);
    check("t3_frames", frame_count, 2);
    ready_mode = 0;
    repeat (2) @(posedge clk);

    // Oversized 6-word frame dropped, following 3-word frame kept.
    do_clear();
    ready_mode = 2;
    repeat (2) @(posedge clk);
    base = beats_seen;
    send_frame(5, 384, 0, 0);
    send_frame(6, 192, 1, 0);
    repeat (3) @(negedge clk);
    check("t4_drops",  drop_count, 1);
    check("t4_frames", frame_count, 1);
    check("t4_held_valid", m_axis_tvalid, 1);
    ready_mode = 0;
    drain("t4");
    check("t4_beats", 64'(beats_seen - base), 64'd24);

    // Reset after 10 beats of a frame, then a clean frame.
    base = beats_seen;
    send_frame(7, 192, 1, 0);
    wait_beats(base + 10);
    #1 rst_n = 1'b0;
    #1;
    check("t5_tvalid", m_axis_tvalid, 0);
    check("t5_tlast",  m_axis_tlast, 0);
    check("t5_tdata",  m_axis_tdata, 0);
    check("t5_tkeep",  m_axis_tkeep, 0);
    check("t5_frames", frame_count, 0);
    check("t5_drops",  drop_count, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    base = beats_seen;
    send_frame(8, 192, 1, 0);
    drain("t5");
    check("t5_beats_after",  64'(beats_seen - base), 64'd24);
    check("t5_frames_after", frame_count, 1);

    // 20 oversized frames saturate drop_count; clear wins over a drop.
    do_clear();
    for (int f = 0; f < 20; f++) send_frame(10 + f, 320, 0, 0);
    @(negedge clk);
    check("t6_drop_sat", drop_count, 15);
    send_frame(40, 320, 0, 1);
    @(negedge clk);
    check("t6_clear_drop", drop_count, 0);
    check("t6_frames",     frame_count, 0);
    repeat (5) @(posedge clk);
    check("t6_no_output", m_axis_tvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packetgen_egress.md
# packetgen_egress

Egress stage for the wide packet generator: accepts the generator's unstallable S_DATA_WIDTH AXI-Stream, buffers whole frames in a frame FIFO, and serialises them onto an M_DATA_WIDTH AXI-Stream that honours m_axis_tready. Frames that cannot be fully buffered are dropped atomically and counted. It replaces the fixed 64-bit, always-ready output path and sits between packetgen and the MAC/TX interface.

## Interface
- S_DATA_WIDTH, 512: input width in bits; must be an integer multiple of M_DATA_WIDTH.
- M_DATA_WIDTH, 64: output width in bits; S_DATA_WIDTH/M_DATA_WIDTH (RATIO) must be a power of two, 1 to 64.
- DEPTH, 64: FIFO depth in S-words; must be a power of two, at least 2.
- COUNT_WIDTH, 32: width of the statistics counters.
- clk  in  1  single clock; every register is clocked on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- s_axis_tdata  in  S_DATA_WIDTH  input data; byte 0 is in bits [7:0].
- s_axis_tkeep  in  S_DATA_WIDTH/8  byte enables; contiguous from the LSB.
- s_axis_tvalid  in  1  beat present. There is no tready: every valid beat is consumed.
- s_axis_tlast  in  1  last beat of the frame.
- m_axis_tdata  out  M_DATA_WIDTH  output data.
- m_axis_tkeep  out  M_DATA_WIDTH/8  output byte enables.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last output beat of the frame.
- clear_counters  in  1  synchronous clear of both counters; takes priority over increments.
- frame_count  out  COUNT_WIDTH  committed frames; saturates at all-ones.
- drop_count  out  COUNT_WIDTH  dropped frames; saturates at all-ones.

## Operation
- Ingress FSM states:
  - IDLE: waiting for the first beat of a frame.
  - ACCEPT: writing the current frame.
  - DROP: discarding the current frame.
- Transitions:
  - IDLE, or ACCEPT after tlast, with a valid beat: write the beat if the FIFO has space. If the beat has tlast, commit the frame, otherwise go to ACCEPT. If there is no space, go to DROP.
  - ACCEPT, valid beat with the FIFO full: rewind wr_ptr to the frame's start pointer and go to DROP.
  - DROP: discard beats up to and including tlast. On tlast, increment drop_count and return to IDLE.
- A dropped single-beat frame (tlast with no space) increments drop_count and stays in IDLE.
- A frame longer than DEPTH words is always dropped.
- Commit: wr_commit ← wr_ptr+1 in the tlast cycle, and frame_count increments.
- The read side sees only committed words.
- Space check:
  - Uses the registered rd_ptr, so a word freed in the same cycle is not visible.
  - "Full" means wr_ptr − rd_ptr = DEPTH.
  - Pointers are one bit wider than log2(DEPTH) and wrap modulo 2·DEPTH.
- Serialiser:
  - Holds one S-word and emits RATIO slices, low-order first.
  - Slice k carries tdata[k·M+M−1 : k·M] with the matching tkeep bits.
  - On a non-last word, all RATIO slices are emitted.
  - On the last word, slices stop after the highest slice with a nonzero keep. That slice carries m_axis_tlast.
  - Non-last input words must have full tkeep; this is not checked.
- The serialiser prefetches the next committed word so that back-to-back words and frames stream without bubbles.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, frame_count=0, drop_count=0. The FSM is in IDLE and all pointers are 0.
- Latency: a tlast sampled in cycle N (FIFO previously empty) gives m_axis_tvalid=1 in cycle N+2.
- Throughput: one M-beat per cycle while m_axis_tready=1.
- Handshake: while m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs hold stable. tvalid never drops without a transfer.
- Counters update in the cycle after the commit or drop event.
- Reset mid-operation:
  - All buffered and partial frames are lost; the output returns to tvalid=0 immediately.
  - A downstream frame cut off this way has no tlast.
  - After reset, input beats before the next frame start are treated as a new frame start.

## Structure
- Shared package packetgen_pkg holds:
  - the ingress state enum (IDLE, ACCEPT, DROP);
  - a clog2 function;
  - a last_slice(keep) function returning the highest nonzero slice index.
- Sub-module packetgen_frame_fifo: dual-pointer RAM with wr_ptr, wr_commit, rewind and full/empty outputs.
- The FSM, serialiser and counters stay in the top level.

## Test plan
- 192-byte frame, 512→64: 3 full S-beats → 24 M-beats with tkeep=0xFF, tlast only on beat 24, frame_count=1.
- 60-byte frame in one S-beat (keep = low 60 bits set) → 8 M-beats, beat 8 tkeep=0x0F and tlast=1, no further beats.
- Two 192-byte frames back-to-back with m_axis_tready toggling 1,0,0,1 → data and keep stable while stalled, 48 beats in order.
- DEPTH=4, m_axis_tready=0, a 6-beat frame then a 3-beat frame → drop_count=1, frame_count=1. After tready=1, only the 3-beat frame appears (24 M-beats).
- rst_n asserted after 10 M-beats of a frame → outputs at reset values in the same cycle, counters 0. A subsequent frame passes intact.
- COUNT_WIDTH=4, 20 dropped frames → drop_count saturates at 15. clear_counters together with a drop event → drop_count=0.
